// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads mainmem combinationally and
// buffers {pc, insn} pairs in a small in-order queue toward decode.
module fetch_unit #(
  parameter logic [31:0] START_PC = 32'h0100_0000,
  parameter int          DEPTH    = 4
) (
  input  logic                       clock,
  input  logic                       reset_n,
  output logic [31:0]                mem_address,
  output logic                       mem_read_write,
  output logic [31:0]                mem_data_in,
  input  logic [31:0]                mem_data_out,
  input  logic                       fetch_enable,
  input  logic                       redirect_valid,
  input  logic [31:0]                redirect_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_insn,
  output logic [31:0]                out_pc,
  output logic [$clog2(DEPTH):0]     q_count
);
  localparam int AW = $clog2(DEPTH);

  logic [31:0]   pc_q, pc_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [DEPTH-1:0][31:0] insn_q, epc_q;

  logic pop, full, push;

  // Handshake qualifiers; mem_address depends only on pc_q, never on out_ready
  always_comb begin
    pop  = (cnt_q != '0) & out_ready;
    full = (cnt_q == (AW+1)'(DEPTH));
    push = fetch_enable & ~redirect_valid & (~full | pop);
  end

  assign mem_address    = pc_q;
  assign mem_read_write = 1'b0;
  assign mem_data_in    = 32'h0;
  assign out_valid      = (cnt_q != '0);
  assign out_insn       = insn_q[rp_q];
  assign out_pc         = epc_q[rp_q];
  assign q_count        = cnt_q;

  // Next-state: redirect flushes everything and wins over push/pop
  always_comb begin
    pc_d  = pc_q;
    cnt_d = cnt_q;
    wp_d  = wp_q;
    rp_d  = rp_q;
    if (redirect_valid) begin
      pc_d  = {redirect_pc[31:2], 2'b00};
      cnt_d = '0;
      wp_d  = '0;
      rp_d  = '0;
    end else begin
      if (push) begin
        wp_d = wp_q + AW'(1);
        pc_d = pc_q + 32'd4;
      end
      if (pop) rp_d = rp_q + AW'(1);
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + (AW+1)'(1);
        2'b01:   cnt_d = cnt_q - (AW+1)'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Control state registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_q  <= START_PC;
      cnt_q <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
    end else begin
      pc_q  <= pc_d;
      cnt_q <= cnt_d;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
    end
  end

  // Queue storage; cleared on reset so outputs are never X while empty
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      insn_q <= '0;
      epc_q  <= '0;
    end else if (push) begin
      insn_q[wp_q] <= mem_data_out;
      epc_q[wp_q]  <= pc_q;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: vector table plus hand-written sequences.
module tb_fetch_unit;
  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic [31:0] mem_address, mem_data_in, mem_data_out;
  logic        mem_read_write;
  logic        fetch_enable = 1'b0, redirect_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        out_valid;
  logic [31:0] out_insn, out_pc;
  logic [2:0]  q_count;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  fetch_unit #(.START_PC(32'h0100_0000), .DEPTH(4)) dut (
    .clock(clock), .reset_n(reset_n),
    .mem_address(mem_address), .mem_read_write(mem_read_write),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
    .fetch_enable(fetch_enable), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_insn(out_insn), .out_pc(out_pc), .q_count(q_count)
  );

  // Combinational memory model
  function automatic logic [31:0] memf(input logic [31:0] a);
    case (a)
      32'h0100_0000: memf = 32'h0000_0513;
      32'h0100_0004: memf = 32'h0010_0593;
      default:       memf = a ^ 32'h5A5A_0F0F;
    endcase
  endfunction
  assign mem_data_out = memf(mem_address);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        fe, rdy, rv;
    logic [31:0] rpc;
    logic        ev;
    logic [2:0]  ecnt;
    logic [31:0] eaddr, epc;
  } vec_t;

  vec_t v[17];

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    chk("rst_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_count", {29'b0, q_count}, 32'h0);
    chk("rst_addr", mem_address, 32'h0100_0000);
    chk("rst_insn", out_insn, 32'h0);
    chk("rst_pc", out_pc, 32'h0);
    chk("rst_rw", {31'b0, mem_read_write}, 32'h0);
    chk("rst_din", mem_data_in, 32'h0);
  endtask

  initial begin
    // fe rdy rv rpc | valid cnt addr out_pc
    v[0]  = '{1,0,0,32'h0,          1,3'd1,32'h0100_0004,32'h0100_0000};
    v[1]  = '{1,0,0,32'h0,          1,3'd2,32'h0100_0008,32'h0100_0000};
    v[2]  = '{1,0,0,32'h0,          1,3'd3,32'h0100_000C,32'h0100_0000};
    v[3]  = '{1,0,0,32'h0,          1,3'd4,32'h0100_0010,32'h0100_0000};
    v[4]  = '{1,0,0,32'h0,          1,3'd4,32'h0100_0010,32'h0100_0000};
    v[5]  = '{1,1,0,32'h0,          1,3'd4,32'h0100_0014,32'h0100_0004};
    v[6]  = '{0,1,0,32'h0,          1,3'd3,32'h0100_0014,32'h0100_0008};
    v[7]  = '{1,1,1,32'h0100_0103,  0,3'd0,32'h0100_0100,32'h0};
    v[8]  = '{1,1,0,32'h0,          1,3'd1,32'h0100_0104,32'h0100_0100};
    v[9]  = '{1,0,0,32'h0,          1,3'd2,32'h0100_0108,32'h0100_0100};
    v[10] = '{0,1,0,32'h0,          1,3'd1,32'h0100_0108,32'h0100_0104};
    v[11] = '{0,1,0,32'h0,          0,3'd0,32'h0100_0108,32'h0};
    v[12] = '{0,1,0,32'h0,          0,3'd0,32'h0100_0108,32'h0};
    v[13] = '{0,1,1,32'hFFFF_FFFC,  0,3'd0,32'hFFFF_FFFC,32'h0};
    v[14] = '{1,0,0,32'h0,          1,3'd1,32'h0000_0000,32'hFFFF_FFFC};
    v[15] = '{1,1,0,32'h0,          1,3'd1,32'h0000_0004,32'h0000_0000};
    v[16] = '{1,1,0,32'h0,          1,3'd1,32'h0000_0008,32'h0000_0004};

    #1;
    // Sequence 1: reset release with consumer ready
    fetch_enable = 1'b1; out_ready = 1'b1;
    do_reset();
    reset_n = 1'b1;
    @(negedge clock);
    chk("s1_valid0", {31'b0, out_valid}, 32'h1);
    chk("s1_pc0", out_pc, 32'h0100_0000);
    chk("s1_insn0", out_insn, 32'h0000_0513);
    @(negedge clock);
    chk("s1_pc1", out_pc, 32'h0100_0004);
    chk("s1_insn1", out_insn, 32'h0010_0593);

    // Sequence 2: asynchronous reset between edges
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_valid", {31'b0, out_valid}, 32'h0);
    chk("arst_count", {29'b0, q_count}, 32'h0);
    chk("arst_addr", mem_address, 32'h0100_0000);

    // Table: fill, full push/pop, redirect, drain, wrap
    out_ready = 1'b0;
    do_reset();
    reset_n = 1'b1;
    for (int i = 0; i < 17; i++) begin
      fetch_enable = v[i].fe; out_ready = v[i].rdy;
      redirect_valid = v[i].rv; redirect_pc = v[i].rpc;
      @(negedge clock);
      chk($sformatf("v%0d_valid", i), {31'b0, out_valid}, {31'b0, v[i].ev});
      chk($sformatf("v%0d_count", i), {29'b0, q_count}, {29'b0, v[i].ecnt});
      chk($sformatf("v%0d_addr", i), mem_address, v[i].eaddr);
      if (v[i].ev) begin
        chk($sformatf("v%0d_pc", i), out_pc, v[i].epc);
        chk($sformatf("v%0d_insn", i), out_insn, memf(v[i].epc));
      end
      chk($sformatf("v%0d_rw", i), {31'b0, mem_read_write}, 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
